// File: rtl/spi_upcounter_pkg.sv
// Shared types and constants for the SPI up-counter command receiver.
// Frame layout: CMD, DATA_HI, DATA_LO, MSB first.
package spi_upcounter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_CMD,
        RX_HI,
        RX_LO,
        WAIT_CS
    } rx_state_t;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;
    localparam logic [3:0] STATUS_TAG  = 4'h5;
    localparam int         FRAME_BITS  = 24;

    function automatic logic [7:0] status_byte(
        input logic clear,
        input logic runstop
    );
        return {STATUS_TAG, 2'b00, clear, runstop};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop pin synchronizer with rise/fall detection on the synced value.
// Edges compare the synced value against its one-cycle-delayed copy.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] pipe;
    logic              prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe <= '0;
            prev <= 1'b0;
        end else begin
            pipe <= {pipe[STAGES-2:0], i_async};
            prev <= pipe[STAGES-1];
        end
    end

    assign o_sync = pipe[STAGES-1];
    assign o_rise = o_sync & ~prev;
    assign o_fall = ~o_sync & prev;

endmodule

// File: rtl/spi_upcounter_slave_rx.sv
// SPI mode-0 slave receiving 3-byte run/stop/clear/count command frames.
// Returns a status byte on MISO during the command byte.
module spi_upcounter_slave_rx
    import spi_upcounter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_sclk,
    input  logic              i_mosi,
    input  logic              i_cs_n,
    output logic              o_miso,
    output logic              o_runstop,
    output logic              o_clear,
    output logic [DATA_W-1:0] o_count,
    output logic              o_frame_valid,
    output logic              o_frame_err
);

    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic mosi_sync, mosi_rise, mosi_fall;
    logic cs_sync, cs_rise, cs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .reset(reset), .i_async(i_sclk),
        .o_sync(sclk_sync), .o_rise(sclk_rise), .o_fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
        .clk(clk), .reset(reset), .i_async(i_mosi),
        .o_sync(mosi_sync), .o_rise(mosi_rise), .o_fall(mosi_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
        .clk(clk), .reset(reset), .i_async(i_cs_n),
        .o_sync(cs_sync), .o_rise(cs_rise), .o_fall(cs_fall)
    );

    rx_state_t   state, state_n;
    logic [4:0]  bit_cnt;
    logic [23:0] rx_shift;
    logic [23:0] rx_next;
    logic [7:0]  tx_shift;
    logic [7:0]  status;
    logic [15:0] data16;
    logic        start, sample, commit, reject;
    logic        unused_bits;

    assign rx_next = {rx_shift[22:0], mosi_sync};
    assign data16  = rx_next[15:0];
    assign status  = status_byte(o_clear, o_runstop);
    assign start   = cs_fall && (state == IDLE || state == WAIT_CS);

    // Only the edge/level outputs that the protocol needs are consumed.
    assign unused_bits = ^{sclk_sync, mosi_rise, mosi_fall,
                           rx_shift[23], rx_next[19:18]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        sample  = 1'b0;
        commit  = 1'b0;
        reject  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) state_n = RX_CMD;
            end
            RX_CMD, RX_HI: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    reject  = 1'b1;
                end else if (sclk_rise && !cs_sync) begin
                    sample = 1'b1;
                    if (state == RX_CMD && bit_cnt == 5'd7)
                        state_n = RX_HI;
                    else if (state == RX_HI && bit_cnt == 5'd15)
                        state_n = RX_LO;
                end
            end
            RX_LO: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    reject  = 1'b1;
                end else if (sclk_rise && !cs_sync) begin
                    sample = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = WAIT_CS;
                        if (rx_next[23:20] == SYNC_NIBBLE) commit = 1'b1;
                        else                               reject = 1'b1;
                    end
                end
            end
            WAIT_CS: begin
                if (cs_rise)      state_n = IDLE;
                else if (cs_fall) state_n = RX_CMD;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            o_miso        <= 1'b0;
            o_runstop     <= 1'b0;
            o_clear       <= 1'b0;
            o_count       <= '0;
            o_frame_valid <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            o_frame_valid <= commit;
            o_frame_err   <= reject;
            if (start) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (sample) begin
                bit_cnt  <= bit_cnt + 5'd1;
                rx_shift <= rx_next;
            end
            // Status snapshot is taken at the frame start; zeros follow it.
            if (start) begin
                o_miso   <= status[7];
                tx_shift <= {status[6:0], 1'b0};
            end else if (cs_rise) begin
                o_miso   <= 1'b0;
                tx_shift <= '0;
            end else if (sclk_fall && state != IDLE) begin
                o_miso   <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (commit) begin
                o_runstop <= rx_next[16];
                o_clear   <= rx_next[17];
                o_count   <= data16[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_spi_upcounter_slave_rx.sv
// Bench for spi_upcounter_slave_rx: frame-level model plus per-clock output compare.
// Directed frames followed by randomized frames of random length.
module tb_spi_upcounter_slave_rx;

    localparam int SYNC_STAGES = 2;
    localparam int DATA_W      = 14;
    localparam int WIN         = SYNC_STAGES + 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic cs_n = 1'b1;
    logic o_miso, o_runstop, o_clear, o_frame_valid, o_frame_err;
    logic [DATA_W-1:0] o_count;

    spi_upcounter_slave_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .DATA_W(DATA_W)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .i_sclk(sclk),
        .i_mosi(mosi),
        .i_cs_n(cs_n),
        .o_miso(o_miso),
        .o_runstop(o_runstop),
        .o_clear(o_clear),
        .o_count(o_count),
        .o_frame_valid(o_frame_valid),
        .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model state packed as {runstop, clear, count}.
    logic [DATA_W+1:0] cur = '0;
    logic [DATA_W+1:0] prev = '0;
    int settle = 0;
    int valid_seen = 0;
    int err_seen = 0;
    int cs_hi_clks = 0;
    logic pv = 1'b0;
    logic pe = 1'b0;
    logic [DATA_W+1:0] dut_out;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        dut_out = {o_runstop, o_clear, o_count};
        total++;
        if (!(dut_out === cur || (settle > 0 && dut_out === prev))) begin
            bad++;
            $display("FAIL outputs at %0t: got %0h expected %0h",
                     $time, dut_out, cur);
        end
        if (o_frame_valid || o_frame_err) begin
            total++;
            if (settle == 0) begin
                bad++;
                $display("FAIL pulse_window at %0t: got v=%0b e=%0b expected none",
                         $time, o_frame_valid, o_frame_err);
            end
        end
        if ((pv && o_frame_valid) || (pe && o_frame_err)) begin
            total++;
            bad++;
            $display("FAIL pulse_width at %0t: got >1 clk expected 1 clk", $time);
        end
        if (settle > 0) settle--;
        if (o_frame_valid) valid_seen++;
        if (o_frame_err) err_seen++;
        pv = o_frame_valid;
        pe = o_frame_err;
        if (cs_n) cs_hi_clks++;
        else cs_hi_clks = 0;
        if (cs_hi_clks > SYNC_STAGES + 3 && o_miso !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL miso_idle at %0t: got %0b expected 0", $time, o_miso);
        end
    end

    task automatic frame(input logic [31:0] bits, input int nbits,
                         input int rst_at, output logic [31:0] rd);
        logic [7:0]  st;
        logic [15:0] d16;
        logic [31:0] exp_rd;
        logic [31:0] mask;
        int v0, e0;
        bit good, aborted;
        st = {4'h5, 2'b00, cur[DATA_W], cur[DATA_W+1]};
        good = (bits[31:28] == 4'hA);
        aborted = 1'b0;
        v0 = valid_seen;
        e0 = err_seen;
        rd = '0;
        cs_n = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            if (rst_at != 0 && i == rst_at) begin
                rst_n = 1'b0;
                cur = '0;
                prev = '0;
                settle = 0;
                aborted = 1'b1;
                #1;
                check("rst_runstop", 32'(o_runstop), 32'd0);
                check("rst_clear", 32'(o_clear), 32'd0);
                check("rst_count", 32'(o_count), 32'd0);
                check("rst_miso", 32'(o_miso), 32'd0);
                break;
            end
            mosi = bits[31-i];
            #100 sclk = 1'b1;
            rd[31-i] = o_miso;
            if (i == 23) begin
                prev = cur;
                if (good) begin
                    d16 = bits[23:8];
                    cur = {bits[24], bits[25], d16[DATA_W-1:0]};
                end
                settle = WIN;
            end
            #100 sclk = 1'b0;
        end
        #100 cs_n = 1'b1;
        if (nbits < 24 && !aborted) begin
            prev = cur;
            settle = WIN;
        end
        #300;
        if (aborted) begin
            rst_n = 1'b1;
            #300;
        end
        check("valid_pulses", 32'(valid_seen - v0),
              32'(!aborted && nbits >= 24 && good));
        check("err_pulses", 32'(err_seen - e0),
              32'(!aborted && (nbits < 24 || !good)));
        if (!aborted) begin
            mask = ~(32'hFFFF_FFFF >> nbits);
            exp_rd = {st, 24'h0} & mask;
            check("miso_bits", rd & mask, exp_rd);
        end
    endtask

    logic [31:0] rd;
    logic [31:0] rbits;
    int rlen;

    initial begin
        #1;
        check("reset_runstop", 32'(o_runstop), 32'd0);
        check("reset_count", 32'(o_count), 32'd0);
        check("reset_valid", 32'(o_frame_valid), 32'd0);
        #50 rst_n = 1'b1;
        #200;

        frame(32'hA1270F00, 24, 0, rd);
        check("t1_count", 32'(o_count), 32'h270F);
        check("t1_runstop", 32'(o_runstop), 32'd1);
        check("t1_clear", 32'(o_clear), 32'd0);

        frame(32'hA2000000, 24, 0, rd);
        check("t2_clear", 32'(o_clear), 32'd1);
        check("t2_runstop", 32'(o_runstop), 32'd0);
        check("t2_count", 32'(o_count), 32'd0);
        frame(32'hA0000500, 24, 0, rd);
        check("t2b_clear", 32'(o_clear), 32'd0);
        check("t2b_count", 32'(o_count), 32'd5);

        frame(32'h51123400, 24, 0, rd);
        check("t3_count", 32'(o_count), 32'd5);

        frame(32'hA1000100, 13, 0, rd);
        check("t4_short_count", 32'(o_count), 32'd5);
        frame(32'hA1000100, 24, 0, rd);
        check("t4_count", 32'(o_count), 32'd1);

        frame(32'hA10002FC, 30, 0, rd);
        check("t5_byte0", 32'(rd[31:24]), 32'h51);
        check("t5_byte12", 32'(rd[23:8]), 32'h0);
        check("t5_count", 32'(o_count), 32'd2);

        frame(32'hA3123400, 24, 10, rd);
        frame(32'hA1000700, 24, 0, rd);
        check("t6_count", 32'(o_count), 32'd7);
        check("t6_runstop", 32'(o_runstop), 32'd1);

        for (int n = 0; n < 25; n++) begin
            rbits = $urandom;
            if ($urandom_range(0, 3) != 0) rbits[31:28] = 4'hA;
            case ($urandom_range(0, 9))
                0: rlen = $urandom_range(1, 23);
                1: rlen = $urandom_range(25, 31);
                default: rlen = 24;
            endcase
            frame(rbits, rlen, 0, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
